// File: rtl/cajero_teclado.sv
// -----------------------------------------------------------------------------
// cajero_teclado
// Keypad front-end for the Cajero FSM. Debounces a raw key-down level,
// samples the 4-bit key code on acceptance and either forwards a single PIN
// digit or builds a decimal amount that is committed on ENTER.
//
// Build option: define KEY_DEBOUNCE_EN to enable the DEBOUNCE_CYCLES filters.
// Without it, one high sample accepts a press and one low sample releases it.
//
// Ports
//   CLK           in   1   rising-edge clock
//   RESET         in   1   asynchronous active-low reset
//   TECLA_VALIDA  in   1   raw key-down level (may bounce)
//   TECLA         in   4   key code: 0-9 digit, A BORRAR, B ENTER, C-F ignored
//   MODO_MONTO    in   1   0 = PIN entry, 1 = amount entry
//   DIGITO        out  4   last accepted PIN digit
//   DIGITO_STB    out  1   1-cycle pulse, DIGITO valid
//   MONTO         out  32  last committed amount
//   MONTO_STB     out  1   1-cycle pulse, MONTO valid
//   MONTO_ERROR   out  1   1-cycle pulse, digit rejected (accumulator full)
//   CANT_DIGITOS  out  4   digits currently held in the accumulator
// -----------------------------------------------------------------------------
module cajero_teclado #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int MAX_DIGITOS     = 9
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        TECLA_VALIDA,
    input  logic [3:0]  TECLA,
    input  logic        MODO_MONTO,
    output logic [3:0]  DIGITO,
    output logic        DIGITO_STB,
    output logic [31:0] MONTO,
    output logic        MONTO_STB,
    output logic        MONTO_ERROR,
    output logic [3:0]  CANT_DIGITOS
);

    localparam logic [1:0] REPOSO        = 2'd0;
    localparam logic [1:0] FILTRO_ALTO   = 2'd1;
    localparam logic [1:0] ESPERA_SOLTAR = 2'd2;
    localparam logic [1:0] FILTRO_BAJO   = 2'd3;

    localparam logic [3:0] K_BORRAR = 4'hA;
    localparam logic [3:0] K_ENTER  = 4'hB;
    localparam logic [3:0] MAX_CANT = 4'(MAX_DIGITOS);

    // acc*10 + d using shifts only; wraps in 32 bits
    function automatic logic [31:0] f_acc_decimal(input logic [31:0] acc,
                                                  input logic [3:0]  d);
        return (acc << 3) + (acc << 1) + {28'd0, d};
    endfunction

    logic [1:0]  r_estado;
    logic [1:0]  w_estado_sig;
    logic        w_acepta;

`ifdef KEY_DEBOUNCE_EN
    localparam int         CW       = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_ULT = CW'(DEBOUNCE_CYCLES - 1);

    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_sig;

    // r_cnt holds how many equal samples have been seen so far in a FILTRO state;
    // the sample that makes it DEBOUNCE_CYCLES completes the filter.
    always_comb begin
        w_estado_sig = r_estado;
        w_cnt_sig    = r_cnt;
        w_acepta     = 1'b0;
        case (r_estado)
            REPOSO: begin
                if (TECLA_VALIDA) begin
                    if (DEBOUNCE_CYCLES <= 1) begin
                        w_acepta     = 1'b1;
                        w_estado_sig = ESPERA_SOLTAR;
                    end else begin
                        w_cnt_sig    = CW'(1);
                        w_estado_sig = FILTRO_ALTO;
                    end
                end
            end
            FILTRO_ALTO: begin
                if (!TECLA_VALIDA) begin
                    w_estado_sig = REPOSO;
                end else if (r_cnt == CNT_ULT) begin
                    w_acepta     = 1'b1;
                    w_estado_sig = ESPERA_SOLTAR;
                end else begin
                    w_cnt_sig = r_cnt + CW'(1);
                end
            end
            ESPERA_SOLTAR: begin
                if (!TECLA_VALIDA) begin
                    if (DEBOUNCE_CYCLES <= 1) begin
                        w_estado_sig = REPOSO;
                    end else begin
                        w_cnt_sig    = CW'(1);
                        w_estado_sig = FILTRO_BAJO;
                    end
                end
            end
            default: begin
                if (TECLA_VALIDA) begin
                    w_estado_sig = ESPERA_SOLTAR;
                end else if (r_cnt == CNT_ULT) begin
                    w_estado_sig = REPOSO;
                end else begin
                    w_cnt_sig = r_cnt + CW'(1);
                end
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_cnt_sig;
        end
    end
`else
    // Unfiltered: a single sample decides press and release.
    always_comb begin
        w_estado_sig = r_estado;
        w_acepta     = 1'b0;
        case (r_estado)
            REPOSO: begin
                if (TECLA_VALIDA) begin
                    w_acepta     = 1'b1;
                    w_estado_sig = ESPERA_SOLTAR;
                end
            end
            ESPERA_SOLTAR: begin
                if (!TECLA_VALIDA) begin
                    w_estado_sig = REPOSO;
                end
            end
            FILTRO_ALTO, FILTRO_BAJO: w_estado_sig = ESPERA_SOLTAR;
            default:                  w_estado_sig = ESPERA_SOLTAR;
        endcase
    end
`endif

    // Reset parks the FSM in ESPERA_SOLTAR so a key held through reset
    // must be released before it can be accepted.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_estado <= ESPERA_SOLTAR;
        end else begin
            r_estado <= w_estado_sig;
        end
    end

    logic        r_modo;
    logic [31:0] r_acc;
    logic [3:0]  r_cant;
    logic [3:0]  r_digito;
    logic        r_digito_stb;
    logic [31:0] r_monto;
    logic        r_monto_stb;
    logic        r_monto_error;

    // A mode change wipes the accumulator; a key accepted on the same edge
    // starts from the cleared values in the new mode.
    logic        w_cambio_modo;
    logic [31:0] w_acc_base;
    logic [3:0]  w_cant_base;

    assign w_cambio_modo = (MODO_MONTO != r_modo);
    assign w_acc_base    = w_cambio_modo ? 32'd0 : r_acc;
    assign w_cant_base   = w_cambio_modo ? 4'd0  : r_cant;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_modo        <= 1'b0;
            r_acc         <= '0;
            r_cant        <= '0;
            r_digito      <= '0;
            r_digito_stb  <= 1'b0;
            r_monto       <= '0;
            r_monto_stb   <= 1'b0;
            r_monto_error <= 1'b0;
        end else begin
            r_modo        <= MODO_MONTO;
            r_acc         <= w_acc_base;
            r_cant        <= w_cant_base;
            r_digito_stb  <= 1'b0;
            r_monto_stb   <= 1'b0;
            r_monto_error <= 1'b0;
            if (w_acepta) begin
                if (!MODO_MONTO) begin
                    if (TECLA <= 4'd9) begin
                        r_digito     <= TECLA;
                        r_digito_stb <= 1'b1;
                    end
                end else if (TECLA <= 4'd9) begin
                    if (w_cant_base < MAX_CANT) begin
                        r_acc  <= f_acc_decimal(w_acc_base, TECLA);
                        r_cant <= w_cant_base + 4'd1;
                    end else begin
                        r_monto_error <= 1'b1;
                    end
                end else if (TECLA == K_BORRAR) begin
                    r_acc  <= '0;
                    r_cant <= '0;
                end else if (TECLA == K_ENTER) begin
                    if (w_cant_base != 4'd0) begin
                        r_monto     <= w_acc_base;
                        r_monto_stb <= 1'b1;
                        r_acc       <= '0;
                        r_cant      <= '0;
                    end
                end
            end
        end
    end

    assign DIGITO       = r_digito;
    assign DIGITO_STB   = r_digito_stb;
    assign MONTO        = r_monto;
    assign MONTO_STB    = r_monto_stb;
    assign MONTO_ERROR  = r_monto_error;
    assign CANT_DIGITOS = r_cant;

endmodule
